// File: rtl/m_bin2bcd_disp.sv
// Iterative double-dabble binary-to-BCD converter feeding the 8-digit 7-segment display.
// Optional leading-zero blank mask enabled by defining BIN2BCD_ZERO_BLANK_EN.
module m_bin2bcd_disp #(
    parameter int NBITS = 32,
    parameter int NDIG  = 8
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    input  logic                w_start,
    input  logic [31:0]         w_bin,
    output logic                r_busy,
    output logic                r_done,
    output logic [4*NDIG-1:0]   r_bcd,
    output logic                r_ovf,
    output logic [NDIG-1:0]     r_blank
);

    localparam int              CW      = $clog2(NBITS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NBITS - 1);
    localparam logic [31:0]     MAX_DEC  = 32'd99999999;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [NBITS-1:0]    shift_q, shift_d;
    logic [4*NDIG-1:0]   acc_q, acc_d;
    logic [4*NDIG-1:0]   adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction uses the pre-shift digit values, all digits in parallel.
    always_comb begin
        adj = acc_q;
        for (int k = 0; k < NDIG; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_ZERO_BLANK_EN
    logic [NDIG-1:0] blank_q, blank_d;
    logic [NDIG-1:0] blank_calc;
    logic            seen_nz;

    always_comb begin
        blank_calc = '0;
        seen_nz    = 1'b0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            seen_nz       = seen_nz | (acc_q[4*k +: 4] != 4'd0);
            blank_calc[k] = ~seen_nz;
        end
    end
`endif

    always_comb begin
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
`ifdef BIN2BCD_ZERO_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    shift_d    = w_bin[NBITS-1:0];
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (w_bin > MAX_DEC);
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                acc_d   = (adj << 1) | {{(4*NDIG-1){1'b0}}, shift_q[NBITS-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                bcd_d  = ovf_pend_q ? {NDIG{4'h9}} : acc_q;
                ovf_d  = ovf_pend_q;
                done_d = 1'b1;
                busy_d = 1'b0;
`ifdef BIN2BCD_ZERO_BLANK_EN
                blank_d = ovf_pend_q ? '0 : blank_calc;
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef BIN2BCD_ZERO_BLANK_EN
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end
    assign r_blank = blank_q;
`else
    assign r_blank = '0;
`endif

    assign r_busy = busy_q;
    assign r_done = done_q;
    assign r_bcd  = bcd_q;
    assign r_ovf  = ovf_q;

endmodule

// File: tb/tb_m_bin2bcd_disp.sv
// Self-checking bench for m_bin2bcd_disp: directed vector table, multi-cycle corner
// sequences and a random sweep, all checked through an expected-result queue.
module tb_m_bin2bcd_disp;

    localparam logic [31:0] SAT = 32'h99999999;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_start;
    logic [31:0] w_bin;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_bcd;
    logic        r_ovf;
    logic [7:0]  r_blank;

    m_bin2bcd_disp dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_start (w_start),
        .w_bin   (w_bin),
        .r_busy  (r_busy),
        .r_done  (r_done),
        .r_bcd   (r_bcd),
        .r_ovf   (r_ovf),
        .r_blank (r_blank)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int cyc = 0;
    always @(posedge w_clk) cyc++;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
    } vec_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   done_seen = 0;
    int   pushes    = 0;

    function automatic logic [7:0] blankExp(input logic [7:0] b);
`ifdef BIN2BCD_ZERO_BLANK_EN
        return b;
`else
        return 8'h00 & b;
`endif
    endfunction

    function automatic exp_t mkExp(input logic [31:0] bcd, input logic ovf, input logic [7:0] blank);
        exp_t e;
        e.bcd     = bcd;
        e.ovf     = ovf;
        e.blank   = blankExp(blank);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Reference decimal model: repeated division by ten, saturating above 99,999,999.
    function automatic exp_t refModel(input logic [31:0] v);
        logic [31:0] bcd;
        logic [7:0]  blank;
        logic [31:0] t;
        logic        nz;
        bcd   = '0;
        blank = '0;
        if (v > 32'd99999999) begin
            return mkExp(SAT, 1'b1, 8'h00);
        end
        t = v;
        for (int k = 0; k < 8; k++) begin
            bcd[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nz = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            if (bcd[4*k +: 4] != 4'd0) nz = 1'b1;
            blank[k] = ~nz;
        end
        return mkExp(bcd, 1'b0, blank);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every r_done must match the oldest outstanding request.
    always @(negedge w_clk) begin : monitor
        exp_t e;
        if (r_done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: r_done high with no request outstanding, r_bcd=0x%08h", r_bcd);
            end else begin
                e = sb.pop_front();
                checkOutput("bcd",     r_bcd,              e.bcd);
                checkOutput("ovf",     {31'b0, r_ovf},     {31'b0, e.ovf});
                checkOutput("blank",   {24'b0, r_blank},   {24'b0, e.blank});
                checkOutput("latency", 32'(cyc - e.acc_cyc), 32'd33);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (r_busy !== 1'b0 && n < 200) begin
            @(negedge w_clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: r_busy=%0b, required 0 within 200 cycles", r_busy);
        end
    endtask

    // Called on a falling edge; the request is accepted on the next rising edge.
    task automatic applyStimulus(input logic [31:0] v, input exp_t e);
        exp_t ex;
        waitIdle();
        ex         = e;
        w_start    = 1'b1;
        w_bin      = v;
        ex.acc_cyc = cyc + 1;
        sb.push_back(ex);
        pushes++;
        @(negedge w_clk);
        w_start = 1'b0;
        w_bin   = $urandom;
    endtask

    task automatic pulseIgnored(input logic [31:0] v);
        checkOutput("busy_during_ignored_start", {31'b0, r_busy}, 32'd1);
        w_start = 1'b1;
        w_bin   = v;
        @(negedge w_clk);
        w_start = 1'b0;
        w_bin   = $urandom;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge w_clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{32'd0,         32'h00000000, 1'b0, 8'hFE};
        tbl[1] = '{32'd12345678,  32'h12345678, 1'b0, 8'h00};
        tbl[2] = '{32'd905,       32'h00000905, 1'b0, 8'hF8};
        tbl[3] = '{32'd99999999,  32'h99999999, 1'b0, 8'h00};
        tbl[4] = '{32'd100000000, 32'h99999999, 1'b1, 8'h00};
        tbl[5] = '{32'hFFFFFFFF,  32'h99999999, 1'b1, 8'h00};
        tbl[6] = '{32'd10000000,  32'h10000000, 1'b0, 8'h00};
        tbl[7] = '{32'd9,         32'h00000009, 1'b0, 8'hFE};

        w_rst_n = 1'b0;
        w_start = 1'b0;
        w_bin   = '0;
        #17;
        checkOutput("reset_busy",  {31'b0, r_busy},   32'd0);
        checkOutput("reset_done",  {31'b0, r_done},   32'd0);
        checkOutput("reset_bcd",   r_bcd,             32'd0);
        checkOutput("reset_ovf",   {31'b0, r_ovf},    32'd0);
        checkOutput("reset_blank", {24'b0, r_blank},  32'd0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(negedge w_clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].bin, mkExp(tbl[i].bcd, tbl[i].ovf, tbl[i].blank));
        end
        waitDrain();

        // Starts during a conversion are ignored; a start in the r_done cycle is accepted.
        applyStimulus(32'd42, mkExp(32'h00000042, 1'b0, 8'hFC));
        repeat (4) @(negedge w_clk);
        pulseIgnored(32'd7);
        repeat (14) @(negedge w_clk);
        pulseIgnored(32'd7);
        waitIdle();
        checkOutput("b2b_start_in_done_cycle", {31'b0, r_done}, 32'd1);
        applyStimulus(32'd7, mkExp(32'h00000007, 1'b0, 8'hFE));
        waitDrain();
        repeat (40) @(negedge w_clk);
        checkOutput("done_count_after_ignored", 32'(done_seen), 32'(pushes));

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(32'd555, mkExp(32'h00000555, 1'b0, 8'hF8));
        waitDrain();
        applyStimulus(32'd1234, mkExp(32'h00001234, 1'b0, 8'hF0));
        repeat (8) @(posedge w_clk);
        #3;
        w_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'b0, r_busy}, 32'd0);
        checkOutput("async_rst_bcd",  r_bcd,           32'd0);
        checkOutput("async_rst_done", {31'b0, r_done}, 32'd0);
        sb.delete();
        pushes--;
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b1;
        @(negedge w_clk);
        applyStimulus(32'd1234, mkExp(32'h00001234, 1'b0, 8'hF0));
        waitDrain();

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] v;
            v = 32'($urandom_range(99999999, 0));
            applyStimulus(v, refModel(v));
        end
        waitDrain();
        repeat (40) @(negedge w_clk);
        checkOutput("total_done_count", 32'(done_seen), 32'(pushes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
